// File: rtl/tick_countdown.sv
// Millisecond countdown: loads a tick count, runs down on 1 ms ticks, and supports pause/resume and expiry.
// Define TICK_COUNTDOWN_AUTORELOAD_EN to reload from the load register on expiry and keep running.
module tick_countdown #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tick,
  output logic             tick_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             tick_en_q, busy_q, expired_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    if (load) begin
      reload_d    = load_value;
      remaining_d = load_value;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && remaining_q != ZERO) state_d = S_RUN;
        end
        S_RUN: begin
          // A tick arriving with pause is counted before pausing; the last tick overrides pause.
          if (tick && remaining_q > ONE) begin
            remaining_d = remaining_q - ONE;
            if (pause) state_d = S_PAUSE;
          end else if (tick && remaining_q == ONE) begin
            done_d = 1'b1;
`ifdef TICK_COUNTDOWN_AUTORELOAD_EN
            remaining_d = reload_q;
            if (reload_q == ZERO) state_d = S_EXPIRED;
`else
            remaining_d = ZERO;
            state_d     = S_EXPIRED;
`endif
          end else if (pause) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start) state_d = S_RUN;
        end
        S_EXPIRED: begin
          if (start && reload_q != ZERO) begin
            remaining_d = reload_q;
            state_d     = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      done_q      <= 1'b0;
      tick_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      done_q      <= done_d;
      tick_en_q   <= (state_d == S_RUN);
      busy_q      <= (state_d == S_RUN) || (state_d == S_PAUSE);
      expired_q   <= (state_d == S_EXPIRED);
    end
  end

  assign remaining = remaining_q;
  assign tick_en   = tick_en_q;
  assign busy      = busy_q;
  assign expired   = expired_q;
  assign done      = done_q;

endmodule
